// File: rtl/calc_addsub_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : calc_addsub_seq                                              |
// | Brief   : A/op/B token sequencer feeding the add/sub datapath;         |
// |           optional result chaining under CALC_CHAIN_RESULT_EN.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module calc_addsub_seq #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_kind,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_op,
   input  logic [WIDTH-1:0] add_s,
   input  logic             add_cout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_carry,
   output logic             res_ovf,
   output logic             seq_err
);

   localparam logic [1:0] c_kind_operand = 2'b00;
   localparam logic [1:0] c_kind_add     = 2'b01;
   localparam logic [1:0] c_kind_sub     = 2'b10;
   localparam logic [1:0] c_kind_clear   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GOT_A  = 3'd1,
      S_GOT_OP = 3'd2,
      S_EXEC   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           r_state,     w_state_nxt;
   logic [WIDTH-1:0] r_add_a,     w_add_a_nxt;
   logic [WIDTH-1:0] r_add_b,     w_add_b_nxt;
   logic             r_add_op,    w_add_op_nxt;
   logic             r_res_valid, w_res_valid_nxt;
   logic [WIDTH-1:0] r_res_data,  w_res_data_nxt;
   logic             r_res_carry, w_res_carry_nxt;
   logic             r_res_ovf,   w_res_ovf_nxt;
   logic             r_seq_err,   w_seq_err_nxt;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_ovf;

   assign w_in_ready = (r_state == S_IDLE) || (r_state == S_GOT_A) || (r_state == S_GOT_OP);
   assign w_accept   = in_valid && w_in_ready;

   // Signed overflow: effective operand signs agree but the result sign differs.
   assign w_ovf = (r_add_a[WIDTH-1] == (r_add_b[WIDTH-1] ^ r_add_op)) &&
                  (add_s[WIDTH-1] != r_add_a[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_add_op    <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_carry <= 1'b0;
         r_res_ovf   <= 1'b0;
         r_seq_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_add_a     <= w_add_a_nxt;
         r_add_b     <= w_add_b_nxt;
         r_add_op    <= w_add_op_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_res_data  <= w_res_data_nxt;
         r_res_carry <= w_res_carry_nxt;
         r_res_ovf   <= w_res_ovf_nxt;
         r_seq_err   <= w_seq_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_add_a_nxt     = r_add_a;
      w_add_b_nxt     = r_add_b;
      w_add_op_nxt    = r_add_op;
      w_res_valid_nxt = r_res_valid;
      w_res_data_nxt  = r_res_data;
      w_res_carry_nxt = r_res_carry;
      w_res_ovf_nxt   = r_res_ovf;
      w_seq_err_nxt   = r_seq_err;

      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               unique case (in_kind)
                  c_kind_operand: begin
                     w_add_a_nxt = in_data;
                     w_state_nxt = S_GOT_A;
                  end
                  c_kind_clear: w_seq_err_nxt = 1'b0;
                  default:      w_seq_err_nxt = 1'b1;
               endcase
            end
         end
         S_GOT_A: begin
            if (w_accept) begin
               unique case (in_kind)
                  c_kind_add: begin
                     w_add_op_nxt = 1'b0;
                     w_state_nxt  = S_GOT_OP;
                  end
                  c_kind_sub: begin
                     w_add_op_nxt = 1'b1;
                     w_state_nxt  = S_GOT_OP;
                  end
                  c_kind_clear: begin
                     w_seq_err_nxt = 1'b0;
                     w_state_nxt   = S_IDLE;
                  end
                  default: w_seq_err_nxt = 1'b1;
               endcase
            end
         end
         S_GOT_OP: begin
            if (w_accept) begin
               unique case (in_kind)
                  c_kind_operand: begin
                     w_add_b_nxt = in_data;
                     w_state_nxt = S_EXEC;
                  end
                  c_kind_clear: begin
                     w_seq_err_nxt = 1'b0;
                     w_state_nxt   = S_IDLE;
                  end
                  default: w_seq_err_nxt = 1'b1;
               endcase
            end
         end
         S_EXEC: begin
            w_res_data_nxt  = add_s;
            w_res_carry_nxt = add_cout;
            w_res_ovf_nxt   = w_ovf;
            w_res_valid_nxt = 1'b1;
            w_state_nxt     = S_DONE;
         end
         S_DONE: begin
            if (r_res_valid && res_ready) begin
               w_res_valid_nxt = 1'b0;
`ifdef CALC_CHAIN_RESULT_EN
               w_add_a_nxt     = r_res_data;
               w_state_nxt     = S_GOT_A;
`else
               w_state_nxt     = S_IDLE;
`endif
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign in_ready  = w_in_ready;
   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign add_op    = r_add_op;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_carry = r_res_carry;
   assign res_ovf   = r_res_ovf;
   assign seq_err   = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_addsub_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_calc_addsub_seq                                           |
// | Brief   : Directed + random bench for calc_addsub_seq with an          |
// |           arithmetic reference model and a behavioural adder.          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_calc_addsub_seq;

   localparam int WIDTH = 10;
   localparam int MOD   = 1 << WIDTH;
   localparam int SMAX  = (1 << (WIDTH-1)) - 1;
   localparam int SMIN  = -(1 << (WIDTH-1));

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_kind;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_op;
   logic [WIDTH-1:0] add_s;
   logic             add_cout;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_carry;
   logic             res_ovf;
   logic             seq_err;

   int vectors    = 0;
   int miscompares = 0;

   calc_addsub_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_data(in_data),
      .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_s(add_s), .add_cout(add_cout),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_carry(res_carry), .res_ovf(res_ovf), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   // Behavioural adder/subtractor standing in for the downstream datapath.
   always_comb begin
      if (add_op) begin
         add_s    = add_a - add_b;
         add_cout = (add_a >= add_b);
      end else begin
         add_s    = add_a + add_b;
         add_cout = ({1'b0, add_a} + {1'b0, add_b}) >= (WIDTH+1)'(MOD);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed run still active, required $finish");
      $fatal(1, "watchdog");
   end

   function automatic int to_signed(input int v);
      return (v > SMAX) ? v - MOD : v;
   endfunction

   // Reference: plain integer arithmetic, modulo and signed-range checks.
   function automatic void model(input int a, input bit sub, input int b,
                                 output int r, output bit c, output bit v);
      int full, sres;
      if (sub) begin
         full = a - b;
         c    = (a >= b);
         sres = to_signed(a) - to_signed(b);
      end else begin
         full = a + b;
         c    = (full >= MOD);
         sres = to_signed(a) + to_signed(b);
      end
      r = ((full % MOD) + MOD) % MOD;
      v = (sres > SMAX) || (sres < SMIN);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] k, input logic [WIDTH-1:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_kind  = k;
      in_data  = d;
      while (in_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) check("send_timeout", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      in_kind  = 2'b00;
      in_data  = '0;
   endtask

   task automatic handshake(input string tag);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic do_op(input int a, input bit sub, input int b, input string tag);
      int er;
      bit ec, ev;
      model(a, sub, b, er, ec, ev);
      send(2'b00, WIDTH'(a));
      send(sub ? 2'b10 : 2'b01, '0);
      send(2'b00, WIDTH'(b));
      check({tag, "_exec_valid"}, {31'd0, res_valid}, 32'd0);
      check({tag, "_exec_ready"}, {31'd0, in_ready}, 32'd0);
      tick();
      check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
      check({tag, "_data"},  {22'd0, res_data},  32'(er));
      check({tag, "_carry"}, {31'd0, res_carry}, {31'd0, ec});
      check({tag, "_ovf"},   {31'd0, res_ovf},   {31'd0, ev});
      handshake(tag);
      send(2'b11, '0);
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_kind   = 2'b00;
      in_data   = '0;
      res_ready = 1'b0;
      repeat (3) tick();
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_seq_err",   {31'd0, seq_err},   32'd0);
      check("rst_add_a",     {22'd0, add_a},     32'd0);
      check("rst_add_op",    {31'd0, add_op},    32'd0);
      rst_n = 1'b1;
      tick();

      do_op(100, 1'b0, 23, "add_100_23");
      do_op(5, 1'b1, 7, "sub_5_7");
      do_op(7, 1'b1, 5, "sub_7_5");
      do_op(511, 1'b0, 1, "add_511_1");
      do_op(1023, 1'b0, 1, "add_3ff_1");
      do_op(512, 1'b1, 1, "sub_200_1");

      // Backpressure: result held, in_ready low, offered token not taken.
      send(2'b00, 10'd200);
      send(2'b01, '0);
      send(2'b00, 10'd100);
      tick();
      in_valid = 1'b1;
      in_kind  = 2'b00;
      in_data  = 10'd55;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", {31'd0, res_valid}, 32'd1);
         check("bp_data",  {22'd0, res_data},  32'd300);
         check("bp_ready", {31'd0, in_ready},  32'd0);
         check("bp_add_a", {22'd0, add_a},     32'd200);
      end
      in_valid = 1'b0;
      handshake("bp");
      send(2'b11, '0);

      // Protocol errors leave state and registers untouched.
      send(2'b01, '0);
      check("err_op_idle", {31'd0, seq_err}, 32'd1);
      send(2'b00, 10'd9);
      check("err_idle_kept_a", {22'd0, add_a}, 32'd9);
      send(2'b00, 10'd33);
      check("err_opnd_gota", {31'd0, seq_err}, 32'd1);
      check("err_gota_a",    {22'd0, add_a},   32'd9);
      send(2'b11, '0);
      check("clear_err", {31'd0, seq_err}, 32'd0);
      check("clear_keeps_a", {22'd0, add_a}, 32'd9);
      send(2'b10, '0);
      check("clear_to_idle", {31'd0, seq_err}, 32'd1);
      send(2'b11, '0);

      // Reset with a result pending.
      send(2'b00, 10'd12);
      send(2'b01, '0);
      send(2'b00, 10'd13);
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready},  32'd1);
      check("mid_rst_add_b", {22'd0, add_b},     32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      do_op(40, 1'b1, 2, "post_rst");

`ifdef CALC_CHAIN_RESULT_EN
      send(2'b00, 10'd3);
      send(2'b01, '0);
      send(2'b00, 10'd4);
      tick();
      check("chain_first", {22'd0, res_data}, 32'd7);
      handshake("chain1");
      check("chain_reload_a", {22'd0, add_a}, 32'd7);
      send(2'b01, '0);
      send(2'b00, 10'd5);
      tick();
      check("chain_second", {22'd0, res_data}, 32'd12);
      handshake("chain2");
      send(2'b11, '0);
      send(2'b01, '0);
      check("chain_clear_idle", {31'd0, seq_err}, 32'd1);
      send(2'b11, '0);
`endif

      for (int i = 0; i < 16; i++) begin
         do_op(int'($urandom_range(0, MOD-1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, MOD-1)), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
